// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in serial-out serializer feeding a downstream SIPO.
// A WIDTH-bit word is accepted through a valid/ready handshake and shifted out
// one bit per clock, in MSB-first or LSB-first order. Done pulses for one cycle
// after the last frame bit. Defining PISO_PARITY_EN appends an even-parity bit
// to every frame.
module piso_serializer #(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic [WIDTH-1:0] Pdata_in,
   input  logic             Load_valid,
   output logic             Load_ready,
   output logic             Dout,
   output logic             Dout_valid,
   output logic             Busy,
   output logic             Done
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef PISO_PARITY_EN
   typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
   typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

   state_t           state, state_n;
   logic [WIDTH-1:0] sreg, sreg_n;
   logic [CW-1:0]    cnt, cnt_n;
   logic             dout_n, valid_n, done_n;
`ifdef PISO_PARITY_EN
   logic             parity, parity_n;
`endif

   // Bit that goes on the wire first for a given register value.
   function automatic logic head(input logic [WIDTH-1:0] w);
      return MSB_FIRST ? w[WIDTH-1] : w[0];
   endfunction

   // Register value once its head bit has been consumed.
   function automatic logic [WIDTH-1:0] tail(input logic [WIDTH-1:0] w);
      return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
   endfunction

   assign Load_ready = (state == IDLE);
   assign Busy       = (state != IDLE);

   // Next-state and next-output decode. The first bit is registered onto Dout
   // at the accept edge, so the shift register then holds only the remaining
   // bits and the counter indexes the bit currently on Dout.
   always_comb begin
      state_n  = state;
      sreg_n   = sreg;
      cnt_n    = cnt;
      dout_n   = 1'b0;
      valid_n  = 1'b0;
      done_n   = 1'b0;
`ifdef PISO_PARITY_EN
      parity_n = parity;
`endif
      case (state)
         IDLE: begin
            if (Load_valid) begin
               state_n  = SHIFT;
               cnt_n    = '0;
               dout_n   = head(Pdata_in);
               sreg_n   = tail(Pdata_in);
               valid_n  = 1'b1;
`ifdef PISO_PARITY_EN
               parity_n = ^Pdata_in;
`endif
            end
         end
         SHIFT: begin
            if (cnt == LAST) begin
`ifdef PISO_PARITY_EN
               state_n = PARITY;
               dout_n  = parity;
               valid_n = 1'b1;
`else
               state_n = IDLE;
               done_n  = 1'b1;
`endif
            end else begin
               cnt_n   = cnt + CW'(1);
               dout_n  = head(sreg);
               sreg_n  = tail(sreg);
               valid_n = 1'b1;
            end
         end
`ifdef PISO_PARITY_EN
         PARITY: begin
            state_n = IDLE;
            done_n  = 1'b1;
         end
`endif
         default: state_n = IDLE;
      endcase
   end

   // State, datapath and registered outputs with synchronous reset.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state      <= IDLE;
         sreg       <= '0;
         cnt        <= '0;
         Dout       <= 1'b0;
         Dout_valid <= 1'b0;
         Done       <= 1'b0;
`ifdef PISO_PARITY_EN
         parity     <= 1'b0;
`endif
      end else begin
         state      <= state_n;
         sreg       <= sreg_n;
         cnt        <= cnt_n;
         Dout       <= dout_n;
         Dout_valid <= valid_n;
         Done       <= done_n;
`ifdef PISO_PARITY_EN
         parity     <= parity_n;
`endif
      end
   end

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: drives one MSB-first and one LSB-first serializer with the
// same inputs and checks both against an expected bit list built from the word.
module tb_piso_serializer;

   logic       Clk = 1'b0;
   logic       Rst = 1'b0;
   logic [3:0] Pdata_in = '0;
   logic       Load_valid = 1'b0;

   logic ready_m, dout_m, valid_m, busy_m, done_m;
   logic ready_l, dout_l, valid_l, busy_l, done_l;
   logic [3:0] sipo = '0;

   int checks = 0;
   int errors = 0;

`ifdef PISO_PARITY_EN
   localparam int FLEN = 5;
`else
   localparam int FLEN = 4;
`endif

   piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m (
      .Clk(Clk), .Rst(Rst), .Pdata_in(Pdata_in), .Load_valid(Load_valid),
      .Load_ready(ready_m), .Dout(dout_m), .Dout_valid(valid_m),
      .Busy(busy_m), .Done(done_m));

   piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
      .Clk(Clk), .Rst(Rst), .Pdata_in(Pdata_in), .Load_valid(Load_valid),
      .Load_ready(ready_l), .Dout(dout_l), .Dout_valid(valid_l),
      .Busy(busy_l), .Done(done_l));

   always #5 Clk = ~Clk;

   // Downstream 4-bit SIPO fed by the MSB-first stream (Q4 = sipo[3]).
   always @(posedge Clk) sipo <= {sipo[2:0], dout_m};

   // Frame bit i: data bits in transmit order, then the even-parity bit.
   function automatic logic exp_bit(input logic [3:0] w, input bit msb, input int i);
      if (i == 4) return ^w;
      return msb ? w[3 - i] : w[i];
   endfunction

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   // Load w, then check every frame cycle and the Done cycle on both instances.
   // During the frame, noise drives random Load_valid/Pdata_in; the cycle
   // before Done presents hold/nxt so a back-to-back load can follow.
   task automatic frame(input logic [3:0] w, input bit noise, input bit hold,
                        input logic [3:0] nxt, input string name);
      logic [4:0] em, el;
      Pdata_in   = w;
      Load_valid = 1'b1;
      checks++;
      if ({ready_m, ready_l} !== 2'b11) begin
         errors++;
         $display("FAIL %s ready: got %b required 11", name, {ready_m, ready_l});
      end
      for (int i = 0; i < FLEN; i++) begin
         step();
         em = {exp_bit(w, 1'b1, i), 4'b1100};
         el = {exp_bit(w, 1'b0, i), 4'b1100};
         checks++;
         if ({dout_m, valid_m, busy_m, ready_m, done_m} !== em ||
             {dout_l, valid_l, busy_l, ready_l, done_l} !== el) begin
            errors++;
            $display("FAIL %s bit%0d: got msb=%b lsb=%b required msb=%b lsb=%b", name, i,
                     {dout_m, valid_m, busy_m, ready_m, done_m},
                     {dout_l, valid_l, busy_l, ready_l, done_l}, em, el);
         end
         if (i == FLEN - 1) begin
            Load_valid = hold;
            Pdata_in   = nxt;
         end else if (noise) begin
            Load_valid = 1'($urandom);
            Pdata_in   = 4'($urandom);
         end else begin
            Load_valid = hold;
            Pdata_in   = nxt;
         end
      end
      step();
      checks++;
      if ({dout_m, valid_m, busy_m, ready_m, done_m, dout_l, valid_l, busy_l, ready_l, done_l}
          !== 10'b00011_00011) begin
         errors++;
         $display("FAIL %s done: got %b required 0001100011", name,
                  {dout_m, valid_m, busy_m, ready_m, done_m, dout_l, valid_l, busy_l, ready_l, done_l});
      end
`ifndef PISO_PARITY_EN
      checks++;
      if (sipo !== w) begin
         errors++;
         $display("FAIL %s sipo: got %h required %h", name, sipo, w);
      end
`endif
   endtask

   task automatic test_reset();
      Rst        = 1'b1;
      Load_valid = 1'b1;
      Pdata_in   = 4'hF;
      for (int i = 0; i < 2; i++) begin
         step();
         checks++;
         if ({dout_m, valid_m, busy_m, done_m, dout_l, valid_l, busy_l, done_l} !== 8'b0) begin
            errors++;
            $display("FAIL reset cyc%0d: got %b required 00000000", i,
                     {dout_m, valid_m, busy_m, done_m, dout_l, valid_l, busy_l, done_l});
         end
      end
      Rst        = 1'b0;
      Load_valid = 1'b0;
      step();
      checks++;
      if ({dout_m, valid_m, busy_m, ready_m, done_m, dout_l, valid_l, busy_l, ready_l, done_l}
          !== 10'b00010_00010) begin
         errors++;
         $display("FAIL reset release: got %b required 0001000010",
                  {dout_m, valid_m, busy_m, ready_m, done_m, dout_l, valid_l, busy_l, ready_l, done_l});
      end
   endtask

   task automatic test_single();
      frame(4'b1011, 1'b0, 1'b0, 4'h0, "single");
      step();
      checks++;
      if ({valid_m, done_m, ready_m, valid_l, done_l, ready_l} !== 6'b001_001) begin
         errors++;
         $display("FAIL single idle: got %b required 001001",
                  {valid_m, done_m, ready_m, valid_l, done_l, ready_l});
      end
   endtask

   task automatic test_back_to_back();
      frame(4'hA, 1'b0, 1'b1, 4'h5, "b2b_A");
      frame(4'h5, 1'b0, 1'b0, 4'h0, "b2b_5");
      step();
   endtask

   task automatic test_reset_mid_frame();
      Pdata_in   = 4'hF;
      Load_valid = 1'b1;
      step();
      Load_valid = 1'b0;
      step();
      Rst = 1'b1;
      step();
      checks++;
      if ({dout_m, valid_m, busy_m, ready_m, done_m, dout_l, valid_l, busy_l, ready_l, done_l}
          !== 10'b00010_00010) begin
         errors++;
         $display("FAIL midreset abort: got %b required 0001000010",
                  {dout_m, valid_m, busy_m, ready_m, done_m, dout_l, valid_l, busy_l, ready_l, done_l});
      end
      Rst = 1'b0;
      for (int i = 0; i < FLEN + 1; i++) begin
         step();
         checks++;
         if ({valid_m, busy_m, done_m, valid_l, busy_l, done_l} !== 6'b0) begin
            errors++;
            $display("FAIL midreset quiet%0d: got %b required 000000", i,
                     {valid_m, busy_m, done_m, valid_l, busy_l, done_l});
         end
      end
      frame(4'h6, 1'b0, 1'b0, 4'h0, "midreset_6");
      step();
   endtask

   task automatic test_random();
      for (int n = 0; n < 24; n++) begin
         int gap;
         frame(4'($urandom), 1'b1, 1'b0, 4'($urandom), "random");
         gap = int'($urandom_range(3, 0));
         for (int g = 0; g < gap; g++) begin
            step();
            checks++;
            if ({dout_m, valid_m, busy_m, done_m, dout_l, valid_l, busy_l, done_l} !== 8'b0) begin
               errors++;
               $display("FAIL random gap: got %b required 00000000",
                        {dout_m, valid_m, busy_m, done_m, dout_l, valid_l, busy_l, done_l});
            end
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_reset_mid_frame();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
